// File: rtl/debug_regfile.sv
// Wishbone classic debug register file: NUM_REGS RW words, a free-running cycle counter and a
// saturating write counter. Define DEBUG_REGFILE_LOCK_EN to add a sticky write-lock register.
module debug_regfile #(
    parameter int unsigned NUM_REGS    = 4,
    parameter logic [7:0]  BASE_OFFSET = 8'h08
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic                   wbs_err_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NUM_REGS*32-1:0] dbg_regs_o
);

    localparam logic [5:0] CycIdx = 6'(NUM_REGS);
    localparam logic [5:0] WrIdx  = 6'(NUM_REGS + 1);
`ifdef DEBUG_REGFILE_LOCK_EN
    localparam logic [5:0]  LockIdx  = 6'(NUM_REGS + 2);
    localparam int unsigned NumWords = NUM_REGS + 3;
`else
    localparam int unsigned NumWords = NUM_REGS + 2;
`endif

    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
        $error("debug_regfile: NUM_REGS must be in 1..16");
    end
    if (32'(BASE_OFFSET) + 4 * NumWords > 32'd256 || BASE_OFFSET[1:0] != 2'b00) begin : g_bad_base
        $error("debug_regfile: register window overflows 256 bytes or BASE_OFFSET unaligned");
    end

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
    logic [31:0]               cyc_cnt_q, cyc_cnt_d;
    logic [31:0]               wr_cnt_q, wr_cnt_d;
    logic [31:0]               dat_q, dat_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic                      req, aligned, in_win, locked;
    logic [5:0]                widx;
    logic                      unused_adr;

    // A pending termination masks the request so a held strobe is not sampled twice.
    assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    assign aligned    = wbs_adr_i[1:0] == 2'b00;
    assign in_win     = wbs_adr_i[7:2] >= BASE_OFFSET[7:2];
    assign widx       = wbs_adr_i[7:2] - BASE_OFFSET[7:2];
    assign unused_adr = ^wbs_adr_i[31:8];

`ifdef DEBUG_REGFILE_LOCK_EN
    logic lock_q, lock_d;
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        regs_d    = regs_q;
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        wr_cnt_d  = wr_cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
`ifdef DEBUG_REGFILE_LOCK_EN
        lock_d    = lock_q;
`endif
        if (req) begin
            err_d = 1'b1;
            if (aligned && in_win) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (widx == 6'(k)) begin
                        if (!wbs_we_i) begin
                            ack_d = 1'b1;
                            err_d = 1'b0;
                            dat_d = regs_q[k];
                        end else if (!locked) begin
                            ack_d = 1'b1;
                            err_d = 1'b0;
                            for (int unsigned b = 0; b < 4; b++) begin
                                if (wbs_sel_i[b]) begin
                                    regs_d[k][8*b +: 8] = wbs_dat_i[8*b +: 8];
                                end
                            end
                            if (wr_cnt_q != '1) begin
                                wr_cnt_d = wr_cnt_q + 32'd1;
                            end
                        end
                    end
                end
                if (!wbs_we_i && widx == CycIdx) begin
                    ack_d = 1'b1;
                    err_d = 1'b0;
                    dat_d = cyc_cnt_q;
                end
                if (!wbs_we_i && widx == WrIdx) begin
                    ack_d = 1'b1;
                    err_d = 1'b0;
                    dat_d = wr_cnt_q;
                end
`ifdef DEBUG_REGFILE_LOCK_EN
                if (widx == LockIdx) begin
                    ack_d = 1'b1;
                    err_d = 1'b0;
                    if (!wbs_we_i) begin
                        dat_d = {31'd0, lock_q};
                    end else if (wbs_sel_i[0] && wbs_dat_i[0]) begin
                        lock_d = 1'b1;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            regs_q    <= '0;
            cyc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            cyc_cnt_q <= cyc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

`ifdef DEBUG_REGFILE_LOCK_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_dat_o  = dat_q;
    assign dbg_regs_o = regs_q;

endmodule

// File: tb/tb_debug_regfile.sv
// Bench for debug_regfile: directed scenarios plus randomized transfers scored against an
// address-map model of the register file.
module tb_debug_regfile;

    localparam int unsigned NUM  = 4;
    localparam int unsigned BASE = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat_w;
    logic              ack, err;
    logic [31:0]       dat_r;
    logic [NUM*32-1:0] dbg;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned edge_cnt;

    logic [31:0] m_regs [NUM];
    logic [31:0] m_wr;
    logic        m_lock;

    debug_regfile #(
        .NUM_REGS   (NUM),
        .BASE_OFFSET(8'h08)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_err_o (err),
        .wbs_dat_o (dat_r),
        .dbg_regs_o(dbg)
    );

    always #5 clk = ~clk;

    // Timestamp of rising edges since reset release; CYC_CNT read at edge n returns n-1.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM; k++) m_regs[k] = '0;
        m_wr   = '0;
        m_lock = 1'b0;
    endtask

    task automatic model(input logic w_en, input logic [31:0] a32, input logic [31:0] d,
                         input logic [3:0] s, input int unsigned stamp,
                         output logic e_ack, output logic e_err, output logic [31:0] e_dat);
        int unsigned a, w;
        a     = 32'(a32[7:0]);
        e_ack = 1'b0;
        e_err = 1'b1;
        e_dat = '0;
        if (a % 4 == 0 && a >= BASE) begin
            w = (a - BASE) / 4;
            if (w < NUM) begin
                if (!w_en) begin
                    e_ack = 1'b1; e_dat = m_regs[w];
                end else if (!m_lock) begin
                    e_ack = 1'b1;
                    for (int b = 0; b < 4; b++) if (s[b]) m_regs[w][8*b +: 8] = d[8*b +: 8];
                    if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
                end
            end else if (w == NUM && !w_en) begin
                e_ack = 1'b1; e_dat = stamp - 1;
            end else if (w == NUM + 1 && !w_en) begin
                e_ack = 1'b1; e_dat = m_wr;
`ifdef DEBUG_REGFILE_LOCK_EN
            end else if (w == NUM + 2) begin
                e_ack = 1'b1;
                if (!w_en) e_dat = {31'd0, m_lock};
                else if (s[0] && d[0]) m_lock = 1'b1;
`endif
            end
        end
        if (e_ack) e_err = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic w_en, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        logic              e_ack, e_err;
        logic [31:0]       e_dat;
        logic [NUM*32-1:0] e_regs;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w_en; adr = a; dat_w = d; sel = s;
        @(posedge clk); #1;
        model(w_en, a, d, s, edge_cnt, e_ack, e_err, e_dat);
        for (int k = 0; k < NUM; k++) e_regs[32*k +: 32] = m_regs[k];
        chk({tag, "/ack"}, 128'(ack), 128'(e_ack));
        chk({tag, "/err"}, 128'(err), 128'(e_err));
        chk({tag, "/dat"}, 128'(dat_r), 128'(e_dat));
        chk({tag, "/regs"}, 128'(dbg), 128'(e_regs));
        rd = dat_r;
        // Master drops the strobe while the termination is showing.
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/idle"}, {94'd0, ack, err, dat_r}, 128'd0);
    endtask

    logic [31:0] rd, v1, v2, a_r, d_r;
    logic [3:0]  s_r;
    logic        w_r;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {ack, err, dat_r, dbg}, '0);
        @(negedge clk);
        rst = 1'b0;

        xfer("wr_deadbeef", 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, rd);
        xfer("rd_deadbeef", 1'b0, 32'h08, 32'h0, 4'hF, rd);
        chk("deadbeef_value", 128'(rd), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        xfer("rd_wrcnt1", 1'b0, 32'h1C, 32'h0, 4'hF, rd);
        chk("wrcnt_is_1", 128'(rd), 128'd1);

        xfer("wr_lanes", 1'b1, 32'h0C, 32'h1122_3344, 4'b0101, rd);
        xfer("rd_lanes", 1'b0, 32'h0C, 32'h0, 4'hF, rd);
        chk("lanes_value", 128'(rd), 128'h0000_0000_0000_0000_0000_0000_0022_0044);
        xfer("wr_sel0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd);

        xfer("rd_misalign", 1'b0, 32'h0A, 32'h0, 4'hF, rd);
        xfer("wr_cyccnt", 1'b1, 32'h18, 32'h1234_5678, 4'hF, rd);
        xfer("rd_unmapped", 1'b0, 32'h40, 32'h0, 4'hF, rd);
        xfer("rd_below", 1'b0, 32'h04, 32'h0, 4'hF, rd);

        // Request withdrawn before it is sampled.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h08; dat_w = 32'h5555_5555; sel = 4'hF;
        #2;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("withdrawn", {126'd0, ack, err}, 128'd0);
        xfer("rd_after_withdraw", 1'b0, 32'h08, 32'h0, 4'hF, rd);

        xfer("cyc_a", 1'b0, 32'h18, 32'h0, 4'hF, v1);
        repeat (3) @(negedge clk);
        xfer("cyc_b", 1'b0, 32'h18, 32'h0, 4'hF, v2);
        chk("cyc_delta5", 128'(v2 - v1), 128'd5);

        @(negedge clk);
        force dut.wr_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.wr_cnt_q;
        m_wr = 32'hFFFF_FFFE;
        xfer("wr_to_max", 1'b1, 32'h14, 32'hA5A5_0001, 4'hF, rd);
        xfer("wr_at_max", 1'b1, 32'h14, 32'hA5A5_0002, 4'hF, rd);
        xfer("rd_wrcnt_sat", 1'b0, 32'h1C, 32'h0, 4'hF, rd);
        chk("wrcnt_saturated", 128'(rd), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);

        for (int i = 0; i < 80; i++) begin
            w_r = 1'($urandom_range(0, 1));
            d_r = $urandom;
            s_r = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0, 1:    a_r = {$urandom_range(0, 255), 8'(BASE + 4 * $urandom_range(0, NUM - 1))};
                2:       a_r = 32'(BASE + 4 * (NUM + $urandom_range(0, 1)));
                3:       a_r = 32'(BASE + 4 * (NUM + 2));
                4:       a_r = $urandom;
                default: a_r = 32'(BASE + 4 * $urandom_range(0, NUM - 1) + $urandom_range(1, 3));
            endcase
            xfer("rand", w_r, a_r, d_r, s_r, rd);
        end

        // Async reset clears a showing termination and all state without a clock edge.
        xfer("wr_pre_reset", 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08; sel = 4'hF;
        @(posedge clk); #1;
        chk("pre_reset_ack", 128'(ack), 128'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset", {ack, err, dat_r, dbg}, '0);
        model_reset();
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;

        // Reset arriving mid-transfer aborts it.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0C; dat_w = 32'h7777_7777; sel = 4'hF;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_term", {126'd0, ack, err}, 128'd0);
        xfer("rd_after_abort", 1'b0, 32'h0C, 32'h0, 4'hF, rd);
        xfer("rd_wrcnt_abort", 1'b0, 32'h1C, 32'h0, 4'hF, rd);
        chk("wrcnt_after_reset", 128'(rd), 128'd0);

`ifdef DEBUG_REGFILE_LOCK_EN
        xfer("lock_set", 1'b1, 32'h20, 32'h1, 4'h1, rd);
        xfer("wr_locked", 1'b1, 32'h08, 32'h1357_9BDF, 4'hF, rd);
        chk("locked_err", 128'(err), 128'd0);
        xfer("rd_lock", 1'b0, 32'h20, 32'h0, 4'hF, rd);
        chk("lock_reads_1", 128'(rd), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        xfer("rd_lock_rst", 1'b0, 32'h20, 32'h0, 4'hF, rd);
        chk("lock_reads_0", 128'(rd), 128'd0);
        xfer("wr_unlocked", 1'b1, 32'h08, 32'h1357_9BDF, 4'hF, rd);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
